// File: rtl/rv64i_pipe_pkg.sv
// Shared types and constants for the RV64I inter-stage pipeline registers.
// Covers stage payload layouts, the matching kill masks and the NOP reset payloads.
package rv64i_pipe_pkg;

    localparam int          OCC_W    = 2;
    localparam logic [31:0] INST_NOP = 32'h0000_0013;  // addi x0, x0, 0

    typedef logic [OCC_W-1:0] occ_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
    } if_id_payload_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
        logic [63:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rfile_we;
        logic        pc_we;
        logic        memory_we;
        logic        memory_re;
    } dec_ex_payload_t;

    localparam int IF_ID_W  = $bits(if_id_payload_t);
    localparam int DEC_EX_W = $bits(dec_ex_payload_t);

    // A killed decode/execute beat keeps pc/inst/imm for trace but can no longer write state.
    localparam dec_ex_payload_t DEC_EX_KILL_MASK = '{
        pc: 64'd0, inst: 32'd0, imm: 64'd0, rs1: 5'd0, rs2: 5'd0, rd: 5'h1f,
        rfile_we: 1'b1, pc_we: 1'b1, memory_we: 1'b1, memory_re: 1'b1
    };

    localparam dec_ex_payload_t DEC_EX_NOP = '{
        pc: 64'd0, inst: INST_NOP, imm: 64'd0, rs1: 5'd0, rs2: 5'd0, rd: 5'd0,
        rfile_we: 1'b0, pc_we: 1'b0, memory_we: 1'b0, memory_re: 1'b0
    };

    localparam if_id_payload_t IF_ID_NOP = '{pc: 64'd0, inst: INST_NOP};

endpackage

// File: rtl/rv_pipe_entry.sv
// One pipeline slot: a valid flag plus payload and killed flag.
// Clear drops the beat but leaves the payload registers untouched.
module rv_pipe_entry #(
    parameter int                 DATA_W    = 64,
    parameter logic [DATA_W-1:0]  RESET_VAL = {DATA_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_killed,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic              killed
);

    // Slot state: clear wins over load; payload only changes on load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid  <= 1'b0;
            data   <= RESET_VAL;
            killed <= 1'b0;
        end else if (clear) begin
            valid  <= 1'b0;
        end else if (load) begin
            valid  <= 1'b1;
            data   <= load_data;
            killed <= load_killed;
        end
    end

endmodule

// File: rtl/rv_pipe_stage_chk.sv
// Simulation-only structural checks for rv_pipe_stage occupancy bookkeeping.
module rv_pipe_stage_chk
    import rv64i_pipe_pkg::*;
(
    input logic clk,
    input logic rst,
    input logic main_valid,
    input logic skid_valid,
    input occ_t occupancy
);

    a_skid_behind_main: assert property (@(posedge clk) disable iff (!rst) skid_valid |-> main_valid);
    a_occ_range:        assert property (@(posedge clk) disable iff (!rst) occupancy != 2'd3);

endmodule

// File: rtl/rv_pipe_stage.sv
// Generic valid/ready pipeline register with kill, flush and optional skid entry.
// Holds only the steering; storage lives in rv_pipe_entry instances.
module rv_pipe_stage
    import rv64i_pipe_pkg::*;
#(
    parameter int                DATA_W    = 64,
    parameter logic [DATA_W-1:0] RESET_VAL = {DATA_W{1'b0}},
    parameter logic [DATA_W-1:0] KILL_MASK = {DATA_W{1'b0}},
    parameter int                SKID      = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_kill,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_killed,
    output occ_t              occupancy
);

    logic              main_valid_s;
    logic              skid_valid_s;
    logic              main_load_s;
    logic              main_clear_s;
    logic [DATA_W-1:0] main_src_data_s;
    logic              main_src_killed_s;
    logic [DATA_W-1:0] store_data_s;
    logic              accept_s;
    logic              retire_s;

    assign store_data_s = in_kill ? (in_data & ~KILL_MASK) : in_data;
    assign accept_s     = in_valid & in_ready;
    assign retire_s     = main_valid_s & out_ready;

    rv_pipe_entry #(.DATA_W(DATA_W), .RESET_VAL(RESET_VAL)) u_main (
        .clk         (clk),
        .rst         (rst),
        .clear       (main_clear_s),
        .load        (main_load_s),
        .load_data   (main_src_data_s),
        .load_killed (main_src_killed_s),
        .valid       (main_valid_s),
        .data        (out_data),
        .killed      (out_killed)
    );

    generate
        if (SKID != 0) begin : g_skid
            logic              skid_load_s;
            logic              skid_clear_s;
            logic              skid_next_s;
            logic              ready_r;
            logic [DATA_W-1:0] skid_data_s;
            logic              skid_killed_s;

            // Steering: flush drops everything; a held skid beat refills main on retire.
            always_comb begin
                main_load_s       = 1'b0;
                main_clear_s      = 1'b0;
                main_src_data_s   = store_data_s;
                main_src_killed_s = in_kill;
                skid_load_s       = 1'b0;
                skid_clear_s      = 1'b0;
                if (flush) begin
                    main_clear_s = 1'b1;
                    skid_clear_s = 1'b1;
                end else if (skid_valid_s) begin
                    if (retire_s) begin
                        main_load_s       = 1'b1;
                        main_src_data_s   = skid_data_s;
                        main_src_killed_s = skid_killed_s;
                        skid_clear_s      = 1'b1;
                    end else begin
                        main_load_s = 1'b0;
                    end
                end else if (accept_s) begin
                    if (main_valid_s && !retire_s) begin
                        skid_load_s = 1'b1;
                    end else begin
                        main_load_s = 1'b1;
                    end
                end else if (retire_s) begin
                    main_clear_s = 1'b1;
                end else begin
                    main_clear_s = 1'b0;
                end
            end

            // Next skid occupancy, used to register upstream ready.
            always_comb begin
                skid_next_s = skid_valid_s;
                if (skid_clear_s) begin
                    skid_next_s = 1'b0;
                end else if (skid_load_s) begin
                    skid_next_s = 1'b1;
                end else begin
                    skid_next_s = skid_valid_s;
                end
            end

            // Registered upstream ready: low in reset, high whenever the skid slot is free.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    ready_r <= 1'b0;
                end else begin
                    ready_r <= ~skid_next_s;
                end
            end

            rv_pipe_entry #(.DATA_W(DATA_W), .RESET_VAL(RESET_VAL)) u_skid (
                .clk         (clk),
                .rst         (rst),
                .clear       (skid_clear_s),
                .load        (skid_load_s),
                .load_data   (store_data_s),
                .load_killed (in_kill),
                .valid       (skid_valid_s),
                .data        (skid_data_s),
                .killed      (skid_killed_s)
            );

            assign in_ready = ready_r;
        end else begin : g_single
            // Single slot: accept refills main, retire alone empties it.
            always_comb begin
                main_load_s       = 1'b0;
                main_clear_s      = 1'b0;
                main_src_data_s   = store_data_s;
                main_src_killed_s = in_kill;
                if (flush) begin
                    main_clear_s = 1'b1;
                end else if (accept_s) begin
                    main_load_s = 1'b1;
                end else if (retire_s) begin
                    main_clear_s = 1'b1;
                end else begin
                    main_load_s = 1'b0;
                end
            end

            assign skid_valid_s = 1'b0;
            assign in_ready     = ~main_valid_s | out_ready;
        end
    endgenerate

    assign out_valid = main_valid_s;
    assign occupancy = {1'b0, main_valid_s} + {1'b0, skid_valid_s};

    rv_pipe_stage_chk u_chk (
        .clk        (clk),
        .rst        (rst),
        .main_valid (main_valid_s),
        .skid_valid (skid_valid_s),
        .occupancy  (occupancy)
    );

endmodule

// File: tb/tb_rv_pipe_stage.sv
// Scoreboard bench for rv_pipe_stage: a SKID=1 and a SKID=0 instance share one stimulus stream.
module tb_rv_pipe_stage;

    localparam int         W    = 64;
    localparam logic [W-1:0] MASK = 64'hFF00;
    localparam logic [W-1:0] RV   = 64'h13;

    typedef struct {
        logic [W-1:0] data;
        logic         killed;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_kill = 1'b0;
    logic         flush = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] in_data = 64'd0;

    logic         in_ready_s [2];
    logic         out_valid_s [2];
    logic [W-1:0] out_data_s [2];
    logic         out_killed_s [2];
    logic [1:0]   occ_s [2];

    beat_t exp_q [2][$];
    int    just_pushed [2];
    int    errors = 0;
    int    checks = 0;

    always #5 clk = ~clk;

    rv_pipe_stage #(.DATA_W(W), .RESET_VAL(RV), .KILL_MASK(MASK), .SKID(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s[0]), .in_data(in_data),
        .in_kill(in_kill), .flush(flush), .out_valid(out_valid_s[0]), .out_ready(out_ready),
        .out_data(out_data_s[0]), .out_killed(out_killed_s[0]), .occupancy(occ_s[0])
    );

    rv_pipe_stage #(.DATA_W(W), .RESET_VAL(RV), .KILL_MASK(MASK), .SKID(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s[1]), .in_data(in_data),
        .in_kill(in_kill), .flush(flush), .out_valid(out_valid_s[1]), .out_ready(out_ready),
        .out_data(out_data_s[1]), .out_killed(out_killed_s[1]), .occupancy(occ_s[1])
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Drive one cycle of inputs just after the falling edge and record the beats each stage takes.
    task automatic drive(input logic v, input logic [W-1:0] d, input logic k, input logic f,
                         input logic r, output logic acc0);
        @(negedge clk);
        #1;
        in_valid = v; in_data = d; in_kill = k; flush = f; out_ready = r;
        acc0 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            int    occ;
            logic  rdy;
            beat_t b;
            occ = exp_q[i].size();
            rdy = (i == 0) ? (occ < 2) : (occ == 0 || r);
            if (v && rdy && !f) begin
                b.data   = k ? (d & ~MASK) : d;
                b.killed = k;
                exp_q[i].push_back(b);
                just_pushed[i] = 1;
                if (i == 0) acc0 = 1'b1;
            end
        end
    endtask

    task automatic send(input logic [W-1:0] d, input logic k, input logic r);
        logic acc;
        int   tries;
        acc = 1'b0;
        tries = 0;
        while (!acc && tries < 20) begin
            drive(1'b1, d, k, 1'b0, r, acc);
            tries++;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got no accept required accept of %0h", d);
        end
    endtask

    task automatic idle(input int n, input logic r);
        logic acc;
        for (int j = 0; j < n; j++) drive(1'b0, 64'd0, 1'b0, 1'b0, r, acc);
    endtask

    // Monitor: compare the held state of both stages against the scoreboard, then retire/flush.
    always begin
        @(negedge clk);
        #2;
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                int   occ;
                logic exp_rdy;
                occ = exp_q[i].size() - just_pushed[i];
                exp_rdy = (i == 0) ? (occ < 2) : (occ == 0 || out_ready);
                check($sformatf("occupancy%0d", i), 64'(occ_s[i]), 64'(occ));
                check($sformatf("out_valid%0d", i), 64'(out_valid_s[i]), 64'(occ > 0));
                check($sformatf("in_ready%0d", i), 64'(in_ready_s[i]), 64'(exp_rdy));
                if (occ > 0) begin
                    check($sformatf("out_data%0d", i), out_data_s[i], exp_q[i][0].data);
                    check($sformatf("out_killed%0d", i), 64'(out_killed_s[i]), 64'(exp_q[i][0].killed));
                    if (out_ready) void'(exp_q[i].pop_front());
                end
                if (flush) exp_q[i].delete();
                just_pushed[i] = 0;
            end
        end
    end

    initial begin
        logic acc;
        just_pushed[0] = 0;
        just_pushed[1] = 0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #3 rst = 1'b1;

        for (int b = 1; b <= 8; b++) send(64'(b), 1'b0, 1'b1);
        idle(3, 1'b1);

        send(64'hA, 1'b0, 1'b0);
        send(64'hB, 1'b0, 1'b0);
        idle(2, 1'b0);
        idle(4, 1'b1);

        send(64'h1234, 1'b1, 1'b1);
        send(64'h1234, 1'b0, 1'b1);
        idle(2, 1'b1);

        send(64'hA, 1'b0, 1'b0);
        send(64'hB, 1'b0, 1'b0);
        drive(1'b1, 64'hC, 1'b0, 1'b1, 1'b0, acc);
        idle(3, 1'b1);

        for (int n = 0; n < 400; n++) begin
            drive(($urandom % 4) != 0, {$urandom, $urandom}, ($urandom % 4) == 0,
                  ($urandom % 20) == 0, ($urandom % 4) != 0, acc);
        end
        idle(4, 1'b1);

        send(64'h11, 1'b0, 1'b0);
        send(64'h22, 1'b1, 1'b0);
        idle(1, 1'b0);
        #2 rst = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst_out_valid%0d", i), 64'(out_valid_s[i]), 64'd0);
            check($sformatf("rst_out_data%0d", i), out_data_s[i], RV);
            check($sformatf("rst_out_killed%0d", i), 64'(out_killed_s[i]), 64'd0);
            check($sformatf("rst_occupancy%0d", i), 64'(occ_s[i]), 64'd0);
            exp_q[i].delete();
            just_pushed[i] = 0;
        end
        check("rst_in_ready0", 64'(in_ready_s[0]), 64'd0);
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        #3 rst = 1'b1;

        send(64'h55, 1'b0, 1'b1);
        send(64'h66, 1'b1, 1'b1);
        idle(3, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rv_pipe_stage.md
Name: rv_pipe_stage

Overview:
- Generic, parametrised inter-stage pipeline register for the RV64I core, replacing hand-written per-stage registers (fetch/decode, decode/execute, execute/memory).
- Carries an opaque payload vector with valid/ready handshaking, per-beat kill (squash), whole-stage flush, and an optional 2-entry skid buffer so upstream ready is a register output.
- Packing of rs1/rs2/rd, control bits, immediates, PC and instruction word into the payload is done by the instantiating stage.

Parameters:
- DATA_W, 64: payload width in bits (≥1).
- RESET_VAL, DATA_W'(0): value of out_data after reset; the decode/execute instance uses a packed ADDI x0,x0,0 NOP.
- KILL_MASK, DATA_W'(0): payload bits forced to 0 when a beat is killed (rd address, rfile_we, pc_we, memory_we, memory_re, etc.).
- SKID, 1: 1 = two entries (main + skid), registered in_ready. 0 = single entry, combinational in_ready.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  stage can accept a beat this cycle.
- in_data  in  DATA_W  upstream payload.
- in_kill  in  1  beat is squashed; sampled only when accepted.
- flush  in  1  synchronous drop of all held beats.
- out_valid  out  1  main entry holds a beat.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  DATA_W  main entry payload.
- out_killed  out  1  main entry beat was killed.
- occupancy  out  2  beats held (0..2).

Behaviour:
- Transfers: accept = in_valid & in_ready; retire = out_valid & out_ready.
- Stored payload on accept: in_kill ? (in_data & ~KILL_MASK) : in_data. The killed flag is stored alongside.
- Killed beats still flow and occupy slots. Fields not in KILL_MASK pass through, as the decode invalid path does today.
- Latency: an accepted beat appears on out_* the next cycle. No combinational in→out path.
- Reset (rst=0, async): both entries invalid, out_data=RESET_VAL, out_killed=0, occupancy=0, skid data=RESET_VAL.
  - in_ready: SKID=1 → 0 during reset, 1 from the first clock edge after release. SKID=0 → 1 after release.
- SKID=1: in_ready = ~skid_valid, registered. Update on each clock edge, by case:
  - Main empty, accept: beat → main.
  - Main full, retire, accept, skid empty: new beat → main.
  - Main full, retire, skid full: skid → main, skid empties. No accept is possible since in_ready=0.
  - Main full, no retire, accept: beat → skid, so in_ready=0 next cycle.
  - Main full, retire, no accept: main empties. out_data holds its last value (no clear).
  - Main full, no retire, no accept: hold. This replaces the explicit stall input; out_ready=0 is the stall.
- SKID=0: in_ready = ~out_valid | out_ready, combinational. Single main entry. The skid register is not generated.
- out_valid must stay asserted and out_data/out_killed stable until retire, even while flush is pending.
- flush=1 (highest priority after reset):
  - Next edge: both entries invalid, occupancy=0.
  - A beat presented upstream in the same cycle is dropped, even though in_ready may be 1. Upstream treats it as consumed.
  - A retire in the same cycle still completes downstream.
  - Data registers are not cleared.
- Reset mid-operation (async) discards all beats immediately.
- occupancy = main_valid + skid_valid.
- Assertions (simulation only): skid_valid implies main_valid; occupancy never 3.

Decomposition:
- rv64i_pipe_pkg: packed struct typedefs per stage payload (dec_ex_payload_t, etc.), matching KILL_MASK constants, and NOP reset-value constants derived from the rv64i.svh/rv64i_inst.svh macros.
- One natural sub-module: rv_pipe_entry (a single valid+data+killed register with load/clear).
  - rv_pipe_stage instantiates it once (SKID=0) or twice (SKID=1) and holds only the steering logic.

Test Plan:
- Reset: rst=0 mid-stream with occupancy=2 → out_valid=0, out_data=RESET_VAL, occupancy=0 immediately. After release, in_ready=1 on the first edge.
- Streaming, SKID=1, DATA_W=64, out_ready=1: beats 0x1..0x8 one per cycle → out_data 0x1..0x8 on consecutive cycles one cycle later, in_ready constantly 1, occupancy=1.
- Backpressure: out_ready=0 while sending 0xA, 0xB → occupancy=2, in_ready=0, out_data=0xA held. Raise out_ready → 0xA then 0xB, in_ready=1 after 0xA retires. No loss or duplication.
- Kill: KILL_MASK=0xFF00, in_data=0x1234 with in_kill=1 → out_data=0x0034, out_killed=1. The next unkilled beat 0x1234 gives out_data=0x1234, out_killed=0.
- Flush: occupancy=2 with 0xA, 0xB held; assert flush with in_valid=1, in_data=0xC → next cycle occupancy=0, out_valid=0. 0xC is never output.
- SKID=0: out_ready=0 with main full → in_ready=0 in the same cycle. out_ready=1 and in_valid=1 with 0xD → retire and accept in one cycle, out_data=0xD next cycle.
